// File: rtl/fsm_0_pkg.sv
// rtl/fsm_0_pkg.sv - shared state and region encodings for the fsm_0 AXI write front end
package fsm_0_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Region select taken from two address bits of the AW address.
    typedef enum logic [1:0] {
        REG_VARINT     = 2'b00,
        REG_RAW        = 2'b01,
        REG_VARINT_CLR = 2'b10,
        REG_RAW_CLR    = 2'b11
    } region_t;

endpackage

// File: rtl/fsm_0.sv
// rtl/fsm_0.sv - AXI write slave steering bursts into varint/raw input FIFOs
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   axs_s0_aw*                 write address channel (awsize/awburst unused)
//   axs_s0_w*                  write data channel (no wlast; length from awlen)
//   axs_s0_b*                  write response channel
//   *_fifo_full                target FIFO cannot take a word
//   *_clr / *_push             single-cycle FIFO/index/strobe control strobes
//   wdata, wstrb, index        word, strobe and 1-based beat index for the FIFOs
module fsm_0
    import fsm_0_pkg::*;
#(
    parameter int ADDR_SEL_LSB = 12,
    parameter int INDEX_W      = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         axs_s0_awid,
    input  logic [31:0]        axs_s0_awaddr,
    input  logic [7:0]         axs_s0_awlen,
    input  logic [2:0]         axs_s0_awsize,
    input  logic [1:0]         axs_s0_awburst,
    input  logic               axs_s0_awvalid,
    output logic               axs_s0_awready,
    input  logic [31:0]        axs_s0_wdata,
    input  logic [3:0]         axs_s0_wstrb,
    input  logic               axs_s0_wvalid,
    output logic               axs_s0_wready,
    input  logic               axs_s0_bready,
    output logic [3:0]         axs_s0_bid,
    output logic               axs_s0_bvalid,
    input  logic               varint_in_fifo_full,
    input  logic               raw_data_in_fifo_full,
    output logic               varint_in_fifo_clr,
    output logic               varint_in_fifo_push,
    output logic               varint_in_index_clr,
    output logic               varint_in_index_push,
    output logic               raw_data_in_fifo_clr,
    output logic               raw_data_in_fifo_push,
    output logic               raw_data_in_index_clr,
    output logic               raw_data_in_index_push,
    output logic               raw_data_in_wstrb_clr,
    output logic               raw_data_in_wstrb_push,
    output logic [31:0]        wdata,
    output logic [3:0]         wstrb,
    output logic [INDEX_W-1:0] index
);

    state_t      state;
    region_t     region_q;
    logic [3:0]  id_q;
    logic [7:0]  len_q;
    logic [7:0]  counter;
    // Goes high on the first edge after reset release so awready stays low
    // while reset is held and rises from the first rising edge afterwards.
    logic        run;

    region_t     aw_region;
    logic        aw_fire;
    logic        data_full;
    logic        w_fire;
    logic        last_beat;

    // Burst type and size are fixed by the datapath (32-bit INCR only).
    logic        unused_inputs;
    assign unused_inputs = ^{axs_s0_awsize, axs_s0_awburst, axs_s0_awaddr};

    assign aw_region = region_t'(axs_s0_awaddr[ADDR_SEL_LSB +: 2]);

    assign axs_s0_awready = run && (state == ST_IDLE);
    assign aw_fire        = axs_s0_awvalid && axs_s0_awready;

    // Only the data regions have a FIFO to back-pressure; clear regions
    // swallow their beats regardless of either full flag.
    assign data_full = ((region_q == REG_VARINT) && varint_in_fifo_full) ||
                       ((region_q == REG_RAW)    && raw_data_in_fifo_full);

    assign axs_s0_wready = (state == ST_WRITE) && !data_full;
    assign w_fire        = axs_s0_wvalid && axs_s0_wready;
    assign last_beat     = (counter == len_q);

    assign axs_s0_bvalid = (state == ST_RESP);
    assign axs_s0_bid    = id_q;

    assign wdata = axs_s0_wdata;
    assign wstrb = axs_s0_wstrb;
    // Index counts the current beat too, so it runs 1..256 over a burst.
    assign index = (state == ST_WRITE) ? INDEX_W'({1'b0, counter} + 9'd1) : '0;

    assign varint_in_fifo_push    = w_fire && (region_q == REG_VARINT);
    assign varint_in_index_push   = varint_in_fifo_push && last_beat;
    assign raw_data_in_fifo_push  = w_fire && (region_q == REG_RAW);
    assign raw_data_in_wstrb_push = raw_data_in_fifo_push;
    assign raw_data_in_index_push = raw_data_in_fifo_push && last_beat;

    // Clears fire in the AW acceptance cycle; acceptance lasts one cycle
    // because the FSM leaves IDLE on the same edge.
    assign varint_in_fifo_clr    = aw_fire && (aw_region == REG_VARINT_CLR);
    assign varint_in_index_clr   = varint_in_fifo_clr;
    assign raw_data_in_fifo_clr  = aw_fire && (aw_region == REG_RAW_CLR);
    assign raw_data_in_index_clr = raw_data_in_fifo_clr;
    assign raw_data_in_wstrb_clr = raw_data_in_fifo_clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            region_q <= REG_VARINT;
            id_q     <= '0;
            len_q    <= '0;
            counter  <= '0;
            run      <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (aw_fire) begin
                        id_q     <= axs_s0_awid;
                        len_q    <= axs_s0_awlen;
                        region_q <= aw_region;
                        counter  <= '0;
                        state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_fire) begin
                        counter <= counter + 8'd1;
                        if (last_beat) begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (axs_s0_bready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_0.sv
// tb/tb_fsm_0.sv - self-checking bench for fsm_0
module tb_fsm_0;

    localparam int INDEX_W = 10;

    logic               clk;
    logic               reset;
    logic [3:0]         axs_s0_awid;
    logic [31:0]        axs_s0_awaddr;
    logic [7:0]         axs_s0_awlen;
    logic [2:0]         axs_s0_awsize;
    logic [1:0]         axs_s0_awburst;
    logic               axs_s0_awvalid;
    logic               axs_s0_awready;
    logic [31:0]        axs_s0_wdata;
    logic [3:0]         axs_s0_wstrb;
    logic               axs_s0_wvalid;
    logic               axs_s0_wready;
    logic               axs_s0_bready;
    logic [3:0]         axs_s0_bid;
    logic               axs_s0_bvalid;
    logic               varint_in_fifo_full;
    logic               raw_data_in_fifo_full;
    logic               varint_in_fifo_clr;
    logic               varint_in_fifo_push;
    logic               varint_in_index_clr;
    logic               varint_in_index_push;
    logic               raw_data_in_fifo_clr;
    logic               raw_data_in_fifo_push;
    logic               raw_data_in_index_clr;
    logic               raw_data_in_index_push;
    logic               raw_data_in_wstrb_clr;
    logic               raw_data_in_wstrb_push;
    logic [31:0]        wdata;
    logic [3:0]         wstrb;
    logic [INDEX_W-1:0] index;

    fsm_0 #(.ADDR_SEL_LSB(12), .INDEX_W(INDEX_W)) dut (
        .clk(clk), .reset(reset),
        .axs_s0_awid(axs_s0_awid), .axs_s0_awaddr(axs_s0_awaddr), .axs_s0_awlen(axs_s0_awlen),
        .axs_s0_awsize(axs_s0_awsize), .axs_s0_awburst(axs_s0_awburst),
        .axs_s0_awvalid(axs_s0_awvalid), .axs_s0_awready(axs_s0_awready),
        .axs_s0_wdata(axs_s0_wdata), .axs_s0_wstrb(axs_s0_wstrb),
        .axs_s0_wvalid(axs_s0_wvalid), .axs_s0_wready(axs_s0_wready),
        .axs_s0_bready(axs_s0_bready), .axs_s0_bid(axs_s0_bid), .axs_s0_bvalid(axs_s0_bvalid),
        .varint_in_fifo_full(varint_in_fifo_full), .raw_data_in_fifo_full(raw_data_in_fifo_full),
        .varint_in_fifo_clr(varint_in_fifo_clr), .varint_in_fifo_push(varint_in_fifo_push),
        .varint_in_index_clr(varint_in_index_clr), .varint_in_index_push(varint_in_index_push),
        .raw_data_in_fifo_clr(raw_data_in_fifo_clr), .raw_data_in_fifo_push(raw_data_in_fifo_push),
        .raw_data_in_index_clr(raw_data_in_index_clr), .raw_data_in_index_push(raw_data_in_index_push),
        .raw_data_in_wstrb_clr(raw_data_in_wstrb_clr), .raw_data_in_wstrb_push(raw_data_in_wstrb_push),
        .wdata(wdata), .wstrb(wstrb), .index(index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int vp, vi, rp, ri, rs;
        int vcf, vci, rcf, rci, rcs;
        int last_idx;
    } obs_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
        logic [3:0]  strb;
        int          full_cyc;
        int          bwait;
        int          vp, vi, rp, ri, rs, vclr, rclr, last_idx;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {axs_s0_awready, axs_s0_wready, axs_s0_bid, axs_s0_bvalid,
                varint_in_fifo_clr, varint_in_fifo_push, varint_in_index_clr, varint_in_index_push,
                raw_data_in_fifo_clr, raw_data_in_fifo_push, raw_data_in_index_clr,
                raw_data_in_index_push, raw_data_in_wstrb_clr, raw_data_in_wstrb_push,
                wdata[7:0], wstrb, index};
    endfunction

    task automatic tally(inout obs_t o);
        o.vp  += int'(varint_in_fifo_push);
        o.vi  += int'(varint_in_index_push);
        o.rp  += int'(raw_data_in_fifo_push);
        o.ri  += int'(raw_data_in_index_push);
        o.rs  += int'(raw_data_in_wstrb_push);
        o.vcf += int'(varint_in_fifo_clr);
        o.vci += int'(varint_in_index_clr);
        o.rcf += int'(raw_data_in_fifo_clr);
        o.rci += int'(raw_data_in_index_clr);
        o.rcs += int'(raw_data_in_wstrb_clr);
        if (varint_in_index_push || raw_data_in_index_push) o.last_idx = int'(index);
    endtask

    task automatic idle_inputs();
        axs_s0_awid = '0; axs_s0_awaddr = '0; axs_s0_awlen = '0;
        axs_s0_awsize = 3'd2; axs_s0_awburst = 2'b01; axs_s0_awvalid = 1'b0;
        axs_s0_wdata = '0; axs_s0_wstrb = '0; axs_s0_wvalid = 1'b0; axs_s0_bready = 1'b0;
        varint_in_fifo_full = 1'b0; raw_data_in_fifo_full = 1'b0;
    endtask

    // Drives one complete transaction; the per-beat expectations come from the
    // routing rules: data regions push every accepted beat, the last beat also
    // pushes the index, and only the selected region's full flag stalls.
    task automatic run_txn(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                           input logic [3:0] strb, input int full_cyc, input int full_pct,
                           input int wv_pct, input int bwait, output obs_t o);
        int beat, cyc;
        bit acc;
        logic [1:0] rg;
        logic fa, fb, dfull, exp_acc;
        logic [31:0] d;
        o = '{default: 0};
        rg = addr[13:12];
        axs_s0_awaddr = addr; axs_s0_awlen = len; axs_s0_awid = id; axs_s0_awvalid = 1'b1;
        acc = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk); tally(o); acc = axs_s0_awready;
            @(posedge clk); #1;
        end
        axs_s0_awvalid = 1'b0; axs_s0_awaddr = '0;
        if (!acc) begin check("aw_accept", 0, 1); return; end
        beat = 0; cyc = 0;
        while (beat <= int'(len) && cyc < 400) begin
            fa = ((cyc < full_cyc) || ($urandom_range(0, 99) < full_pct)) && (cyc < 40);
            fb = ((cyc < full_cyc) || ($urandom_range(0, 99) < full_pct)) && (cyc < 40);
            d = (full_pct == 0) ? 32'hA0 + beat : $urandom;
            axs_s0_wvalid = ($urandom_range(0, 99) < wv_pct) || (cyc >= 40);
            axs_s0_wdata = d; axs_s0_wstrb = strb;
            varint_in_fifo_full = fa; raw_data_in_fifo_full = fb;
            dfull = ((rg == 2'b00) && fa) || ((rg == 2'b01) && fb);
            exp_acc = axs_s0_wvalid && !dfull;
            @(negedge clk); tally(o);
            check("wready", axs_s0_wready, !dfull);
            check("push_vec",
                  {varint_in_fifo_push, varint_in_index_push, raw_data_in_fifo_push,
                   raw_data_in_index_push, raw_data_in_wstrb_push},
                  {exp_acc && rg == 2'b00, exp_acc && rg == 2'b00 && beat == int'(len),
                   exp_acc && rg == 2'b01, exp_acc && rg == 2'b01 && beat == int'(len),
                   exp_acc && rg == 2'b01});
            if (exp_acc && rg[1] == 1'b0) begin
                check("index", index, beat + 1);
                check("wdata", wdata, d);
                check("wstrb", wstrb, strb);
            end
            if (axs_s0_wvalid && axs_s0_wready) beat++;
            @(posedge clk); #1;
            cyc++;
        end
        axs_s0_wvalid = 1'b0; varint_in_fifo_full = 1'b0; raw_data_in_fifo_full = 1'b0;
        if (beat <= int'(len)) begin check("beat_timeout", 0, 1); return; end
        axs_s0_bready = 1'b0;
        for (int i = 0; i < bwait; i++) begin
            @(negedge clk); tally(o);
            check("bvalid_hold", {axs_s0_bvalid, axs_s0_awready}, 2'b10);
            @(posedge clk); #1;
        end
        axs_s0_bready = 1'b1;
        @(negedge clk); tally(o);
        check("bvalid", axs_s0_bvalid, 1);
        check("bid", axs_s0_bid, id);
        @(posedge clk); #1;
        axs_s0_bready = 1'b0;
        @(negedge clk); tally(o);
        check("back_idle", {axs_s0_awready, axs_s0_bvalid}, 2'b10);
        @(posedge clk); #1;
    endtask

    task automatic compare_obs(input string tag, input obs_t o, input int vp, input int vi,
                               input int rp, input int ri, input int rs, input int vclr,
                               input int rclr, input int last_idx);
        check({tag, "_vpush"}, o.vp, vp);
        check({tag, "_vidx"}, o.vi, vi);
        check({tag, "_rpush"}, o.rp, rp);
        check({tag, "_ridx"}, o.ri, ri);
        check({tag, "_rstrb"}, o.rs, rs);
        check({tag, "_vclr"}, {o.vcf[7:0], o.vci[7:0]}, {vclr[7:0], vclr[7:0]});
        check({tag, "_rclr"}, {o.rcf[7:0], o.rci[7:0], o.rcs[7:0]}, {rclr[7:0], rclr[7:0], rclr[7:0]});
        check({tag, "_last_idx"}, o.last_idx, last_idx);
    endtask

    vec_t vecs[8];
    obs_t o;

    initial begin
        logic [1:0] rg;
        logic [7:0] len;

        vecs[0] = '{32'h0000_0000, 8'd3, 4'd5,  4'hF, 0, 0, 4, 1, 0, 0, 0, 0, 0, 4};
        vecs[1] = '{32'h0000_1000, 8'd0, 4'd2,  4'h3, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1};
        vecs[2] = '{32'h0000_1000, 8'd2, 4'd7,  4'hF, 3, 0, 0, 0, 3, 1, 3, 0, 0, 3};
        vecs[3] = '{32'h0000_3000, 8'd0, 4'd9,  4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[4] = '{32'h0000_2000, 8'd1, 4'd4,  4'hF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        vecs[5] = '{32'h0000_0000, 8'd0, 4'd15, 4'h5, 2, 5, 1, 1, 0, 0, 0, 0, 0, 1};
        vecs[6] = '{32'h0000_3000, 8'd2, 4'd1,  4'hF, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[7] = '{32'h0001_1004, 8'd1, 4'd3,  4'hC, 0, 1, 0, 0, 2, 1, 2, 0, 0, 2};

        idle_inputs();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_outputs", all_outputs(), 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("awready_after_reset", {axs_s0_awready, axs_s0_bvalid}, 2'b10);
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].addr, vecs[v].len, vecs[v].id, vecs[v].strb,
                    vecs[v].full_cyc, 0, 100, vecs[v].bwait, o);
            compare_obs($sformatf("vec%0d", v), o, vecs[v].vp, vecs[v].vi, vecs[v].rp,
                        vecs[v].ri, vecs[v].rs, vecs[v].vclr, vecs[v].rclr, vecs[v].last_idx);
        end

        // Reset in the middle of a varint burst: no response, no further pushes.
        axs_s0_awaddr = 32'h0; axs_s0_awlen = 8'd3; axs_s0_awid = 4'd6; axs_s0_awvalid = 1'b1;
        @(negedge clk);
        check("mid_aw_ready", axs_s0_awready, 1);
        @(posedge clk); #1;
        axs_s0_awvalid = 1'b0;
        axs_s0_wvalid = 1'b1; axs_s0_wdata = 32'h55; axs_s0_wstrb = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mid_push", {varint_in_fifo_push, varint_in_index_push, index}, {2'b10, 10'(i + 1)});
            @(posedge clk); #1;
        end
        axs_s0_wdata = '0; axs_s0_wstrb = '0;
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs", all_outputs(), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_release_quiet", {axs_s0_wready, axs_s0_bvalid, varint_in_fifo_push}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_after_edge", {axs_s0_awready, axs_s0_wready, axs_s0_bvalid, varint_in_fifo_push}, 4'b1000);
        @(posedge clk); #1;
        axs_s0_wvalid = 1'b0;

        // Randomized transactions against the routing rules.
        for (int t = 0; t < 40; t++) begin
            rg  = 2'($urandom_range(0, 3));
            len = 8'($urandom_range(0, 7));
            run_txn({18'h0, rg, 12'($urandom)}, len, 4'($urandom), 4'($urandom),
                    0, 30, 70, $urandom_range(0, 3), o);
            compare_obs($sformatf("rnd%0d", t), o,
                        (rg == 2'b00) ? int'(len) + 1 : 0, (rg == 2'b00) ? 1 : 0,
                        (rg == 2'b01) ? int'(len) + 1 : 0, (rg == 2'b01) ? 1 : 0,
                        (rg == 2'b01) ? int'(len) + 1 : 0,
                        (rg == 2'b10) ? 1 : 0, (rg == 2'b11) ? 1 : 0,
                        (rg[1] == 1'b0) ? int'(len) + 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
